// File: rtl/mcu_clk_ctrl_pkg.sv
// mcu_clk_ctrl_pkg: shared mode/display typedefs for the MCU clock-enable sequencer
package mcu_clk_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, SLOW = 2'd1, STEP = 2'd2} mode_t;
  typedef enum logic [1:0] {SHOW_MCU = 2'd0, SHOW_ADDR = 2'd1, SHOW_RDATA = 2'd2} show_sel_t;
  function automatic show_sel_t toggle_show(show_sel_t s);
    return (s == SHOW_ADDR) ? SHOW_RDATA : SHOW_ADDR;
  endfunction
endpackage

// File: rtl/mcu_clk_ctrl_key.sv
// key_debounce: 2-flop synchroniser, stable-level debounce and press pulse for one active-low key
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic          w_done;
  assign w_done = r_cnt == CW'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_cnt   <= '0;
      level   <= 1'b1;
      press   <= 1'b0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      press   <= 1'b0;
      if (r_sync2 == level) r_cnt <= '0;
      else if (w_done) begin
        r_cnt <= '0;
        level <= r_sync2;
        press <= ~r_sync2;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mcu_clk_ctrl.sv
// mcu_clk_ctrl: RUN/SLOW/STEP clock-enable sequencer and display-source select for the YRV MCU
module mcu_clk_ctrl
  import mcu_clk_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SLOW_DIV        = 8388608
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        key_mode,
  input  logic        key_step,
  input  logic        key_disp,
  output logic        mcu_ce,
  output logic [1:0]  mode,
  output logic [1:0]  show_sel,
  output logic [15:0] step_count
);
  localparam int DW = $clog2(SLOW_DIV);
  mode_t         r_mode;
  show_sel_t     r_show;
  logic [DW-1:0] r_div;
  logic          w_div_end;
  logic          w_mode_p;
  logic          w_step_p;
  logic          w_disp_p;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
    .clk(clk), .reset_n(reset_n), .key_n(key_mode), .level(), .press(w_mode_p));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_step (
    .clk(clk), .reset_n(reset_n), .key_n(key_step), .level(), .press(w_step_p));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_disp (
    .clk(clk), .reset_n(reset_n), .key_n(key_disp), .level(), .press(w_disp_p));
  assign mode      = r_mode;
  assign show_sel  = r_show;
  assign w_div_end = r_div == DW'(SLOW_DIV - 1);
  // a mode press pre-empts any step/disp press seen in the same cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mode     <= RUN;
      r_show     <= SHOW_MCU;
      r_div      <= '0;
      mcu_ce     <= 1'b0;
      step_count <= '0;
    end else begin
      r_div <= '0;
      if (mcu_ce && r_mode != RUN) step_count <= step_count + 16'd1;
      case (r_mode)
        RUN: begin
          mcu_ce <= ~w_mode_p;
          if (w_mode_p) begin
            r_mode     <= SLOW;
            r_show     <= SHOW_ADDR;
            step_count <= '0;
          end
        end
        SLOW: begin
          if (w_mode_p) begin
            r_mode <= STEP;
            mcu_ce <= 1'b0;
          end else begin
            r_div  <= w_div_end ? '0 : r_div + 1'b1;
            mcu_ce <= w_div_end;
            r_show <= w_disp_p ? toggle_show(r_show) : r_show;
          end
        end
        STEP: begin
          if (w_mode_p) begin
            r_mode <= RUN;
            r_show <= SHOW_MCU;
            mcu_ce <= 1'b1;
          end else begin
            mcu_ce <= w_step_p;
            r_show <= w_disp_p ? toggle_show(r_show) : r_show;
          end
        end
        default: begin
          r_mode <= RUN;
          r_show <= SHOW_MCU;
          mcu_ce <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mcu_clk_ctrl.sv
// tb_mcu_clk_ctrl: directed scoreboard bench for mcu_clk_ctrl with DEBOUNCE_CYCLES=4, SLOW_DIV=8
module tb_mcu_clk_ctrl;
  localparam int S_CE = 0, S_MODE = 1, S_SHOW = 2, S_CNT = 3, S_PRESS = 4;
  typedef struct {
    int          at;
    int          sig;
    logic [31:0] val;
    string       tag;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        key_mode = 1'b1;
  logic        key_step = 1'b1;
  logic        key_disp = 1'b1;
  logic        mcu_ce;
  logic [1:0]  mode;
  logic [1:0]  show_sel;
  logic [15:0] step_count;
  exp_t        q[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  mcu_clk_ctrl #(.DEBOUNCE_CYCLES(4), .SLOW_DIV(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .key_mode(key_mode), .key_step(key_step),
    .key_disp(key_disp), .mcu_ce(mcu_ce), .mode(mode), .show_sel(show_sel),
    .step_count(step_count));
  always #5 clk = ~clk;
  function automatic logic [31:0] obs(int s);
    case (s)
      S_CE:    return {31'd0, mcu_ce};
      S_MODE:  return {30'd0, mode};
      S_SHOW:  return {30'd0, show_sel};
      S_CNT:   return {16'd0, step_count};
      default: return {31'd0, u_dut.u_key_step.press};
    endcase
  endfunction
  task automatic ex(int dt, int sig, int v, string t);
    exp_t e;
    int   i;
    e = '{at: cyc + dt, sig: sig, val: 32'(v), tag: t};
    i = 0;
    while (i < q.size() && q[i].at <= e.at) i++;
    q.insert(i, e);
  endtask
  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      o = obs(e.sig);
      n_cmp++;
      assert (e.at == cyc && o === e.val) else begin
        n_err++;
        $error("FAIL %s @cycle %0d (due %0d): observed %0d expected %0d", e.tag, cyc, e.at, o, e.val);
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    drain();
  endtask
  initial begin
    repeat (3) tick();
    ex(1, S_CE, 0, "rst_ce");
    ex(1, S_MODE, 0, "rst_mode");
    ex(1, S_SHOW, 0, "rst_show");
    ex(1, S_CNT, 0, "rst_cnt");
    tick();
    reset_n = 1'b1;
    for (int i = 1; i <= 5; i++) ex(i, S_CE, 1, "run_ce_after_reset");
    ex(5, S_MODE, 0, "run_mode");
    ex(5, S_SHOW, 0, "run_show");
    ex(5, S_CNT, 0, "run_cnt");
    repeat (5) tick();
    // 3-cycle glitch on the mode key must not register
    key_mode = 1'b0;
    repeat (3) tick();
    key_mode = 1'b1;
    for (int i = 1; i <= 10; i++) ex(i, S_MODE, 0, "glitch_mode");
    repeat (10) tick();
    // held press: mode changes at raw edge + 7
    key_mode = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      ex(i, S_CE, int'(i < 7), "enter_slow_ce");
      ex(i, S_MODE, int'(i == 7), "enter_slow_mode");
    end
    ex(7, S_SHOW, 1, "enter_slow_show");
    ex(7, S_CNT, 0, "enter_slow_cnt");
    repeat (7) tick();
    // SLOW: enables every 8 cycles, two disp toggles, then mode press into STEP before the 6th enable
    for (int j = 1; j <= 48; j++) ex(j, S_CE, int'(j % 8 == 0 && j < 47), "slow_ce");
    ex(26, S_SHOW, 1, "slow_show_pre");
    ex(27, S_SHOW, 2, "slow_disp1");
    ex(41, S_SHOW, 1, "slow_disp2");
    ex(41, S_CNT, 5, "slow_cnt5");
    ex(46, S_MODE, 1, "slow_mode_hold");
    ex(47, S_MODE, 2, "enter_step_mode");
    ex(48, S_CNT, 5, "enter_step_cnt");
    for (int j = 1; j <= 48; j++) begin
      tick();
      if (j == 3) key_mode = 1'b1;
      if (j == 20 || j == 34) key_disp = 1'b0;
      if (j == 28 || j == 44) key_disp = 1'b1;
      if (j == 40) key_mode = 1'b0;
      if (j == 46) key_mode = 1'b1;
    end
    // three single steps
    for (int s = 0; s < 3; s++) begin
      key_step = 1'b0;
      for (int k = 1; k <= 14; k++) ex(k, S_CE, int'(k == 7), "step_ce");
      for (int k = 1; k <= 14; k++) begin
        tick();
        if (k == 6) key_step = 1'b1;
      end
    end
    ex(1, S_CNT, 8, "step_cnt8");
    ex(1, S_SHOW, 1, "step_show");
    ex(1, S_MODE, 2, "step_mode");
    tick();
    // STEP -> RUN
    key_mode = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      ex(k, S_MODE, (k >= 7) ? 0 : 2, "to_run_mode");
      ex(k, S_CE, int'(k >= 7), "to_run_ce");
    end
    ex(7, S_SHOW, 0, "to_run_show");
    ex(14, S_CNT, 8, "to_run_cnt_hold");
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 6) key_mode = 1'b1;
    end
    // RUN -> SLOW (count cleared, one slow enable) -> STEP
    key_mode = 1'b0;
    ex(7, S_MODE, 1, "re_slow_mode");
    ex(7, S_CNT, 0, "re_slow_cnt_clr");
    ex(7, S_SHOW, 1, "re_slow_show");
    ex(14, S_CE, 0, "re_slow_ce_gap");
    ex(15, S_CE, 1, "re_slow_first_ce");
    ex(16, S_CNT, 1, "re_slow_cnt1");
    ex(20, S_MODE, 2, "re_step_mode");
    ex(20, S_CE, 0, "re_step_ce");
    for (int k = 1; k <= 26; k++) begin
      tick();
      if (k == 6 || k == 19) key_mode = 1'b1;
      if (k == 13) key_mode = 1'b0;
    end
    // mode and step debounced together: mode wins, step dropped
    key_mode = 1'b0;
    key_step = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      ex(k, S_CE, int'(k >= 7), "simul_ce");
      ex(k, S_MODE, (k >= 7) ? 0 : 2, "simul_mode");
    end
    ex(12, S_CNT, 1, "simul_cnt");
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 6) begin
        key_mode = 1'b1;
        key_step = 1'b1;
      end
    end
    // reset pulse mid-SLOW with the step key held
    key_mode = 1'b0;
    ex(7, S_MODE, 1, "pre_rst_slow");
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 6) key_mode = 1'b1;
    end
    key_step = 1'b0;
    repeat (2) tick();
    reset_n = 1'b0;
    ex(1, S_CE, 0, "midrst_ce");
    ex(1, S_MODE, 0, "midrst_mode");
    ex(1, S_SHOW, 0, "midrst_show");
    ex(1, S_CNT, 0, "midrst_cnt");
    ex(1, S_PRESS, 0, "midrst_press");
    tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      ex(k, S_CE, 1, "post_rst_ce");
      ex(k, S_PRESS, int'(k == 6), "post_rst_step_press");
    end
    ex(10, S_MODE, 0, "post_rst_mode");
    ex(10, S_SHOW, 0, "post_rst_show");
    ex(10, S_CNT, 0, "post_rst_cnt");
    repeat (10) tick();
    key_step = 1'b1;
    repeat (2) tick();
    n_cmp++;
    assert (q.size() == 0) else begin
      n_err++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
